// File: rtl/mp4_core.sv
// mp4_core: multicycle RV32I core driving a 4-beat x 64-bit burst memory port directly.
// Latency: 8 cycles for ALU/branch/jump, 13 for loads, 18 for stores with zero-wait memory.
// Backpressure: each burst beat advances only on pmem_resp; the FSM stalls until it arrives.
module mp4_core #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        commit,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic        halt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // The *_END states are the one idle cycle after the 4th beat with the request dropped.
  typedef enum logic [3:0] {
    S_FETCH, S_FETCH_END, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_RD_END, S_MEM_WR, S_MEM_WR_END, S_WB
  } state_t;

  state_t       state, state_nx;
  logic         run;          // low for the cycle(s) of reset so no request leaks out
  logic [1:0]   cnt;          // beat index within the current burst
  logic [31:0]  pc, ir, rs1_val, rs2_val, imm, res, addr, next_pc;
  logic [255:0] line;
  logic [31:0]  rf [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_load, is_store, wr_en, xfer, take;
  logic [31:0] imm_c, op2, alu, exec_res, exec_npc, ld_word, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  shamt;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  // Reserved funct3 codes on loads/stores are treated as unsupported and retire as NOP.
  assign is_load  = (opcode == OPC_LOAD) && (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
  assign is_store = (opcode == OPC_STORE) && !funct3[2] && (funct3[1:0] != 2'd3);
  assign wr_en    = is_load || (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL)
                 || (opcode == OPC_JALR) || (opcode == OPC_OPIMM) || (opcode == OPC_OP);
  assign xfer     = pmem_resp && (pmem_read || pmem_write);

  // Immediate generation by instruction format.
  always_comb begin
    imm_c = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm_c = {ir[31:12], 12'b0};
      OPC_JAL:            imm_c = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OPC_BRANCH:         imm_c = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_STORE:          imm_c = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      default:            imm_c = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  // ALU, branch compare, writeback value and next PC for the EXEC cycle.
  always_comb begin
    op2   = (opcode == OPC_OP) ? rs2_val : imm;
    shamt = op2[4:0];
    alu   = '0;
    case (funct3)
      3'd0: alu = ((opcode == OPC_OP) && ir[30]) ? rs1_val - op2 : rs1_val + op2;
      3'd1: alu = rs1_val << shamt;
      3'd2: alu = {31'b0, $signed(rs1_val) < $signed(op2)};
      3'd3: alu = {31'b0, rs1_val < op2};
      3'd4: alu = rs1_val ^ op2;
      3'd5: alu = ir[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'd6: alu = rs1_val | op2;
      default: alu = rs1_val & op2;
    endcase
    take = 1'b0;
    case (funct3)
      3'd0: take = (rs1_val == rs2_val);
      3'd1: take = (rs1_val != rs2_val);
      3'd4: take = ($signed(rs1_val) < $signed(rs2_val));
      3'd5: take = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6: take = (rs1_val < rs2_val);
      3'd7: take = (rs1_val >= rs2_val);
      default: take = 1'b0;
    endcase
    exec_res = alu;
    exec_npc = pc + 32'd4;
    case (opcode)
      OPC_LUI:    exec_res = imm;
      OPC_AUIPC:  exec_res = pc + imm;
      OPC_JAL:    begin exec_res = pc + 32'd4; exec_npc = pc + imm; end
      OPC_JALR:   begin exec_res = pc + 32'd4; exec_npc = (rs1_val + imm) & ~32'd1; end
      OPC_BRANCH: if (take) exec_npc = pc + imm;
      default:    exec_res = alu;
    endcase
  end

  // Load extraction from the buffered data line.
  always_comb begin
    ld_word = line[{addr[4:2], 5'b0} +: 32];
    ld_byte = ld_word[{addr[1:0], 3'b0} +: 8];
    ld_half = ld_word[{addr[1], 4'b0} +: 16];
    case (funct3)
      3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_val = {24'b0, ld_byte};
      3'd5:    ld_val = {16'b0, ld_half};
      default: ld_val = ld_word;
    endcase
  end

  // State register; reset returns to FETCH with the request held off for that cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end
  end

  // Next-state sequencing through fetch, decode, execute, memory and writeback.
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:      if (xfer && cnt == 2'd3) state_nx = S_FETCH_END;
      S_FETCH_END:  state_nx = S_DECODE;
      S_DECODE:     state_nx = S_EXEC;
      S_EXEC:       state_nx = (is_load || is_store) ? S_MEM_RD : S_WB;
      S_MEM_RD:     if (xfer && cnt == 2'd3) state_nx = S_MEM_RD_END;
      S_MEM_RD_END: state_nx = is_store ? S_MEM_WR : S_WB;
      S_MEM_WR:     if (xfer && cnt == 2'd3) state_nx = S_MEM_WR_END;
      S_MEM_WR_END: state_nx = S_WB;
      S_WB:         state_nx = S_FETCH;
      default:      state_nx = S_FETCH;
    endcase
  end

  // Memory-port and retirement-trace outputs decoded from the current state.
  always_comb begin
    pmem_read    = run && ((state == S_FETCH) || (state == S_MEM_RD));
    pmem_write   = run && (state == S_MEM_WR);
    pmem_address = (state == S_FETCH) ? {pc[31:5], 5'b0} : {addr[31:5], 5'b0};
    pmem_wdata   = line[{cnt, 6'b0} +: 64];
    commit       = (state == S_WB);
    commit_pc    = commit ? pc : 32'd0;
    commit_inst  = commit ? ir : 32'd0;
    halt         = commit && (next_pc == pc);
  end

  // Datapath registers, line buffer and register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      cnt     <= 2'd0;
      ir      <= '0;
      rs1_val <= '0;
      rs2_val <= '0;
      imm     <= '0;
      res     <= '0;
      addr    <= '0;
      next_pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (xfer) cnt <= cnt + 2'd1;
      case (state)
        S_FETCH, S_MEM_RD: if (xfer) line[{cnt, 6'b0} +: 64] <= pmem_rdata;
        S_FETCH_END: ir <= line[{pc[4:2], 5'b0} +: 32];
        S_DECODE: begin
          rs1_val <= (rs1 == 5'd0) ? 32'd0 : rf[rs1];
          rs2_val <= (rs2 == 5'd0) ? 32'd0 : rf[rs2];
          imm     <= imm_c;
        end
        S_EXEC: begin
          res     <= exec_res;
          next_pc <= exec_npc;
          addr    <= rs1_val + imm;
        end
        S_MEM_RD_END: begin
          if (is_store) begin
            case (funct3[1:0])
              2'd0:    line[{addr[4:0], 3'b0} +: 8]  <= rs2_val[7:0];
              2'd1:    line[{addr[4:1], 4'b0} +: 16] <= rs2_val[15:0];
              default: line[{addr[4:2], 5'b0} +: 32] <= rs2_val;
            endcase
          end else begin
            res <= ld_val;
          end
        end
        S_WB: begin
          if (wr_en && rd != 5'd0) rf[rd] <= res;
          pc <= next_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp4_core.sv
// tb_mp4_core: directed program run against a zero-wait burst memory model.
// Checks reset outputs, commit trace order/latency/halt, store write-back beats and mid-burst reset.
// The memory model answers every request cycle with pmem_resp.
module tb_mp4_core;

  logic        clk, rst;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address, commit_pc, commit_inst;
  logic [63:0] pmem_wdata, pmem_rdata;
  logic        commit, halt;

  mp4_core dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .commit(commit), .commit_pc(commit_pc), .commit_inst(commit_inst), .halt(halt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          gap;
    logic        halt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [63:0] val;
  } wexp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tb_beat = 0;
  int first_rd_cyc = -1;
  logic [31:0] burst_addr;
  logic [63:0] mem [64];
  logic [31:0] c_pc[$], c_inst[$];
  logic        c_halt[$];
  int          c_cyc[$];
  logic [63:0] wr_log[$];
  vec_t        prog[20];
  wexp_t       wx[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] v);
    logic [8:0] off;
    off = a[8:0];
    mem[off[8:3]][{off[2], 5'b0} +: 32] = v;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder and commit/bus monitor, acting on the falling edge.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (commit) begin
        c_pc.push_back(commit_pc);
        c_inst.push_back(commit_inst);
        c_halt.push_back(halt);
        c_cyc.push_back(cyc);
      end
      if (pmem_read || pmem_write) begin
        if (tb_beat == 0) burst_addr = pmem_address;
        checks++;
        if ((pmem_read && pmem_write) || pmem_address[4:0] != 5'd0 || pmem_address != burst_addr) begin
          errors++;
          $display("FAIL bus_protocol: rd %b wr %b addr %h burst_addr %h", pmem_read, pmem_write,
                   pmem_address, burst_addr);
        end
        if (pmem_read && tb_beat == 0 && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (pmem_read) begin
          pmem_rdata = mem[{pmem_address[8:5], 2'(tb_beat)}];
        end else begin
          mem[{pmem_address[8:5], 2'(tb_beat)}] = pmem_wdata;
          wr_log.push_back(pmem_wdata);
        end
        pmem_resp = 1'b1;
        tb_beat   = (tb_beat + 1) % 4;
      end else begin
        pmem_resp = 1'b0;
        tb_beat   = 0;
      end
    end
  end

  initial begin
    prog[0]  = '{32'h00500093, 32'h4000_0000, 8,  1'b0}; // ADDI x1,x0,5
    prog[1]  = '{32'h00108133, 32'h4000_0004, 8,  1'b0}; // ADD x2,x1,x1
    prog[2]  = '{32'h400001B7, 32'h4000_0008, 8,  1'b0}; // LUI x3,0x40000
    prog[3]  = '{32'h1021A023, 32'h4000_000C, 18, 1'b0}; // SW x2,0x100(x3)
    prog[4]  = '{32'h0AB00213, 32'h4000_0010, 8,  1'b0}; // ADDI x4,x0,0xAB
    prog[5]  = '{32'h104181A3, 32'h4000_0014, 18, 1'b0}; // SB x4,0x103(x3)
    prog[6]  = '{32'h10318283, 32'h4000_0018, 13, 1'b0}; // LB x5,0x103(x3)
    prog[7]  = '{32'h1031C303, 32'h4000_001C, 13, 1'b0}; // LBU x6,0x103(x3)
    prog[8]  = '{32'h1051A423, 32'h4000_0020, 18, 1'b0}; // SW x5,0x108(x3)
    prog[9]  = '{32'h1061A623, 32'h4000_0024, 18, 1'b0}; // SW x6,0x10C(x3)
    prog[10] = '{32'hFFF00393, 32'h4000_0028, 8,  1'b0}; // ADDI x7,x0,-1
    prog[11] = '{32'h00100413, 32'h4000_002C, 8,  1'b0}; // ADDI x8,x0,1
    prog[12] = '{32'h0083C463, 32'h4000_0030, 8,  1'b0}; // BLT x7,x8,+8 (taken)
    prog[13] = '{32'h0083E463, 32'h4000_0038, 8,  1'b0}; // BLTU x7,x8,+8 (not taken)
    prog[14] = '{32'h40740533, 32'h4000_003C, 8,  1'b0}; // SUB x10,x8,x7
    prog[15] = '{32'h4043D593, 32'h4000_0040, 8,  1'b0}; // SRAI x11,x7,4
    prog[16] = '{32'h10A1A823, 32'h4000_0044, 18, 1'b0}; // SW x10,0x110(x3)
    prog[17] = '{32'h10B1AA23, 32'h4000_0048, 18, 1'b0}; // SW x11,0x114(x3)
    prog[18] = '{32'h0000006F, 32'h4000_004C, 8,  1'b1}; // JAL x0,0
    prog[19] = '{32'h0000006F, 32'h4000_004C, 8,  1'b1}; // JAL x0,0 again

    wx[0] = '{0,  64'h11223344_0000000A};
    wx[1] = '{1,  64'h99AABBCC_DDEEFF00};
    wx[2] = '{4,  64'h11223344_AB00000A};
    wx[3] = '{5,  64'h99AABBCC_DDEEFF00};
    wx[4] = '{7,  64'h01234567_89ABCDEF};
    wx[5] = '{9,  64'h99AABBCC_FFFFFFAB};
    wx[6] = '{13, 64'h000000AB_FFFFFFAB};
    wx[7] = '{18, 64'h00000000_00000002};
    wx[8] = '{22, 64'hFFFFFFFF_00000002};

    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 20; i++) put_word(prog[i].pc, prog[i].inst);
    put_word(32'h4000_0034, 32'h07700493); // ADDI x9,x0,0x77, skipped by BLT
    mem[32] = 64'h11223344_55667788;
    mem[33] = 64'h99AABBCC_DDEEFF00;
    mem[34] = 64'h0;
    mem[35] = 64'h01234567_89ABCDEF;

    // Reset release
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_commit", commit, 0);
    chk("rst_halt", halt, 0);
    chk("rst_commit_pc", commit_pc, 0);
    chk("rst_commit_inst", commit_inst, 0);
    first_rd_cyc = -1;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("no_commit_before_wb", commit, 0);
      if (pmem_read) break;
    end
    chk("first_read", pmem_read, 1);
    chk("first_read_addr", pmem_address, 64'h4000_0000);

    // Program run: commit trace against the vector table
    for (int k = 0; k < 3000 && c_pc.size() < 20; k++) @(posedge clk);
    chk("commit_count_ok", c_pc.size() >= 20, 1);
    for (int i = 0; i < 20 && i < c_pc.size(); i++) begin
      chk($sformatf("commit_pc[%0d]", i), c_pc[i], prog[i].pc);
      chk($sformatf("commit_inst[%0d]", i), c_inst[i], prog[i].inst);
      chk($sformatf("halt[%0d]", i), c_halt[i], prog[i].halt);
      chk($sformatf("latency[%0d]", i),
          (i == 0) ? c_cyc[0] - first_rd_cyc + 1 : c_cyc[i] - c_cyc[i-1], prog[i].gap);
    end

    // Store write-back beats
    chk("write_beats", wr_log.size(), 24);
    for (int i = 0; i < 9; i++)
      if (wx[i].idx < wr_log.size())
        chk($sformatf("wbeat[%0d]", wx[i].idx), wr_log[wx[i].idx], wx[i].val);
      else
        chk($sformatf("wbeat[%0d]_missing", wx[i].idx), 0, 1);

    // Reset during the 2nd beat of a fetch burst
    begin
      bit hit = 0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #1;
        if (pmem_read && tb_beat == 1) begin hit = 1; break; end
      end
      chk("found_fetch_beat1", hit, 1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midburst_read_drop", pmem_read, 0);
    chk("midburst_commit", commit, 0);
    @(posedge clk); #1;
    c_pc.delete(); c_inst.delete(); c_halt.delete(); c_cyc.delete();
    first_rd_cyc = -1;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (pmem_read) break;
    end
    chk("refetch_read", pmem_read, 1);
    chk("refetch_addr", pmem_address, 64'h4000_0000);
    for (int k = 0; k < 100 && c_pc.size() < 1; k++) @(posedge clk);
    chk("refetch_commit_seen", c_pc.size() >= 1, 1);
    if (c_pc.size() >= 1) begin
      chk("refetch_commit_pc", c_pc[0], 64'h4000_0000);
      chk("refetch_commit_inst", c_inst[0], 64'h0050_0093);
      chk("refetch_latency", c_cyc[0] - first_rd_cyc + 1, 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp4_core.md
Name: mp4_core

Overview:
- Multicycle (non-pipelined) RV32I integer core with no caches.
- Talks directly to a 64-bit burst physical-memory port; each access transfers one 32-byte line as 4 beats.
- Sits at the top of the CPU subsystem, replacing the pipelined datapath and caches for bring-up.
- Exposes a minimal commit/halt trace for the verification monitor.

Parameters:
RESET_PC, 32'h4000_0000, PC loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  32  line address; bits [4:0] always 0.
- pmem_wdata  out  64  write beat data.
- pmem_rdata  in  64  read beat data.
- pmem_resp  in  1  one beat accepted or returned this cycle.
- commit  out  1  one-cycle pulse when an instruction retires.
- commit_pc  out  32  PC of the retiring instruction.
- commit_inst  out  32  encoding of the retiring instruction.
- halt  out  1  commit asserted and next PC equals commit_pc.

Behaviour:
- Reset (rst==0 at a clock edge):
  - PC=RESET_PC; x0..x31=0; FSM=FETCH.
  - pmem_read=pmem_write=0; commit=halt=0; commit_pc=commit_inst=0.
  - Reset mid-burst abandons the burst immediately. Any remaining pmem_resp beats are ignored.
- Burst read:
  - Assert pmem_read with pmem_address={addr[31:5],5'b0}.
  - Hold both signals steady until the 4th pmem_resp.
  - Beat i (i=0..3) holds line bytes 8i..8i+7, little-endian.
  - Deassert in the cycle after the 4th resp.
- Burst write:
  - Assert pmem_write with the address held steady.
  - pmem_wdata = beat 0 first; advance to the next beat on each pmem_resp.
  - Deassert after the 4th resp.
  - pmem_read and pmem_write are never high together.
- FSM states:
  - FETCH: burst-read the line containing PC, then select the word at PC[4:2] → DECODE.
  - DECODE: read rs1/rs2 and form the immediate → EXEC.
  - EXEC: ALU, branch compare and target computation.
    - Loads → MEM_RD.
    - Stores → MEM_RD to fetch the line for read-modify-write.
    - All others → WB.
  - MEM_RD: burst-read the data line.
    - Load → WB.
    - Store → merge bytes under the store mask, then → MEM_WR.
  - MEM_WR: burst-write the merged line → WB.
  - WB: write rd (if rd≠0 and the instruction writes rd); PC=next PC; commit=1 for exactly this cycle → FETCH.
- ISA coverage: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP (incl. SUB/SRA/SRAI).
- Arithmetic rules:
  - All arithmetic is mod 2^32.
  - Shift amount is the low 5 bits.
  - SLT/SLTI are signed; SLTU/SLTIU are unsigned.
  - JALR target = (rs1+imm) & ~1.
  - Link value = PC+4.
- Memory alignment:
  - Loads and stores use the byte offset addr[1:0] within the word at addr[4:2].
  - LH/SH ignore addr[0]; LW/SW ignore addr[1:0] (forced alignment, no trap).
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Unsupported encodings (FENCE, ECALL, EBREAK, illegal opcode) retire as NOP with PC+4 and no register write.
- x0 always reads 0; writes to x0 are discarded.
- halt is combinational: commit && (next PC == commit_pc). The core keeps executing after halt.
- Latency with zero-wait memory (resp on every cycle of request):
  - Non-memory instruction: 8 cycles (FETCH 4+1, DECODE, EXEC, WB).
  - Load: 13 cycles.
  - Store: 18 cycles.

Test Plan:
1. Reset release: hold rst=0 for 2 cycles, then rst=1 → first pmem_read with pmem_address=0x4000_0000; commit stays 0 until the first WB.
2. ADDI x1,x0,5 then ADD x2,x1,x1 → x2=10; two commit pulses with commit_pc 0x4000_0000 and 0x4000_0004.
3. SB of 0xAB to 0x4000_0103, then LB and LBU from the same address → write burst beat 0 changes only byte 3; LB returns 0xFFFF_FFAB, LBU returns 0x0000_00AB.
4. BLT x1,x2 with x1=-1, x2=1 → branch taken; BLTU with the same operands → not taken (PC+4).
5. JAL x0,0 (self-loop) → halt=1 on each of its commits; commit_pc constant.
6. Assert rst=0 during the 2nd beat of a fetch burst → pmem_read drops the next cycle; after release, a fresh fetch starts at RESET_PC.
